// File: rtl/vga_timing_pkg.sv
// Shared video timing constants (640x480@60, 800x600@60) and axis total helpers
// used by the hvgen_param timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int act;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H  = '{act: 32'd640, fp: 32'd16, sync: 32'd96,  bp: 32'd48};
  localparam axis_timing_t VGA640_V  = '{act: 32'd480, fp: 32'd10, sync: 32'd2,   bp: 32'd33};
  localparam axis_timing_t SVGA800_H = '{act: 32'd800, fp: 32'd40, sync: 32'd128, bp: 32'd88};
  localparam axis_timing_t SVGA800_V = '{act: 32'd600, fp: 32'd1,  sync: 32'd4,   bp: 32'd23};

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_last_excl(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage

// File: rtl/hvgen_axis_cnt.sv
// Generic wrapping position counter for one video axis: enable, sync clear,
// terminal count, and active/sync range decodes of the next count value.
module hvgen_axis_cnt #(
  parameter int W       = 10,
  parameter int TOTAL   = 800,
  parameter int ACT     = 640,
  parameter int SYNC_LO = 656,
  parameter int SYNC_HI = 752
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         act,
  output logic         sync
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] nxt_s;

  // Next count and decodes; decodes look at the next value so they line up with it.
  always_comb begin
    tc = (cnt == LAST);
    if (clr) begin
      nxt_s = {W{1'b0}};
    end else if (en) begin
      if (tc) begin
        nxt_s = {W{1'b0}};
      end else begin
        nxt_s = cnt + W'(1);
      end
    end else begin
      nxt_s = cnt;
    end
    // One extra bit so a range ending exactly at 2^W still compares correctly.
    act  = ({1'b0, nxt_s} < (W+1)'(ACT));
    sync = ({1'b0, nxt_s} >= (W+1)'(SYNC_LO)) && ({1'b0, nxt_s} < (W+1)'(SYNC_HI));
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {W{1'b0}};
    end else begin
      cnt <= nxt_s;
    end
  end

endmodule

// File: rtl/hvgen_param.sv
// Parametrised video timing generator (counters, syncs, display enable, strobes).
// Optional frame counter output enabled by defining HVGEN_FRAME_CNT_EN.
module hvgen_param
  import vga_timing_pkg::*;
#(
  parameter int HACTIVE = VGA640_H.act,
  parameter int HFP     = VGA640_H.fp,
  parameter int HSYNC   = VGA640_H.sync,
  parameter int HBP     = VGA640_H.bp,
  parameter int VACTIVE = VGA640_V.act,
  parameter int VFP     = VGA640_V.fp,
  parameter int VSYNC   = VGA640_V.sync,
  parameter int VBP     = VGA640_V.bp,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CW      = 10
) (
  input  logic          pck,
  input  logic          rst,
  input  logic          ce,
  input  logic          resync,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          de,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          line_start,
  output logic          frame_start
`ifdef HVGEN_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int HTOTAL = axis_total(HACTIVE, HFP, HSYNC, HBP);
  localparam int VTOTAL = axis_total(VACTIVE, VFP, VSYNC, VBP);

  logic run_r;
  logic clr_s;
  logic v_en_s;
  logic h_tc_s, v_tc_s;
  logic h_act_s, v_act_s;
  logic h_sync_s, v_sync_s;

  // The first ce after reset and a qualified resync both land on (0,0).
  always_comb begin
    clr_s  = ce & (resync | ~run_r);
    v_en_s = ce & h_tc_s;
  end

  hvgen_axis_cnt #(
    .W      (CW),
    .TOTAL  (HTOTAL),
    .ACT    (HACTIVE),
    .SYNC_LO(sync_first(HACTIVE, HFP)),
    .SYNC_HI(sync_last_excl(HACTIVE, HFP, HSYNC))
  ) u_hcnt (
    .clk (pck),
    .rst (rst),
    .en  (ce),
    .clr (clr_s),
    .cnt (hcnt),
    .tc  (h_tc_s),
    .act (h_act_s),
    .sync(h_sync_s)
  );

  hvgen_axis_cnt #(
    .W      (CW),
    .TOTAL  (VTOTAL),
    .ACT    (VACTIVE),
    .SYNC_LO(sync_first(VACTIVE, VFP)),
    .SYNC_HI(sync_last_excl(VACTIVE, VFP, VSYNC))
  ) u_vcnt (
    .clk (pck),
    .rst (rst),
    .en  (v_en_s),
    .clr (clr_s),
    .cnt (vcnt),
    .tc  (v_tc_s),
    .act (v_act_s),
    .sync(v_sync_s)
  );

  // Registered decodes; everything holds while ce is low, strobes included.
  always_ff @(posedge pck or negedge rst) begin
    if (!rst) begin
      run_r       <= 1'b0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      run_r       <= 1'b1;
      vga_hs      <= h_sync_s ? HS_POL : ~HS_POL;
      vga_vs      <= v_sync_s ? VS_POL : ~VS_POL;
      de          <= h_act_s & v_act_s;
      line_start  <= clr_s | h_tc_s;
      frame_start <= clr_s | (h_tc_s & v_tc_s);
    end else begin
      run_r       <= run_r;
      vga_hs      <= vga_hs;
      vga_vs      <= vga_vs;
      de          <= de;
      line_start  <= line_start;
      frame_start <= frame_start;
    end
  end

`ifdef HVGEN_FRAME_CNT_EN
  logic frame_wrap_s;

  // Only a natural wrap counts a frame; restarts clear the count.
  always_comb begin
    frame_wrap_s = h_tc_s & v_tc_s & ~clr_s;
  end

  // Frame counter register.
  always_ff @(posedge pck or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (ce) begin
      if (clr_s) begin
        frame_cnt <= 16'd0;
      end else if (frame_wrap_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hvgen_param.sv
// Self-checking bench for hvgen_param: default, small (tight CW) and 800x600
// instances share stimulus; a pixel-index model predicts every output each cycle.
module tb_hvgen_param;

  logic pck = 1'b0;
  logic rst, ce, resync;

  logic        hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0]  hcnt_d, vcnt_d;
  logic        hs_s, vs_s, de_s, ls_s, fs_s;
  logic [3:0]  hcnt_s, vcnt_s;
  logic        hs_w, vs_w, de_w, ls_w, fs_w;
  logic [10:0] hcnt_w, vcnt_w;
  logic [15:0] fc_d, fc_s, fc_w;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Timing per instance: 0 = default 640x480, 1 = small 16x10, 2 = 800x600 positive syncs.
  int HA[3]  = '{640, 8, 800};
  int HFP[3] = '{16, 2, 40};
  int HSW[3] = '{96, 3, 128};
  int HBP[3] = '{48, 3, 88};
  int VA[3]  = '{480, 6, 600};
  int VFP[3] = '{10, 1, 1};
  int VSW[3] = '{2, 2, 4};
  int VBP[3] = '{33, 1, 23};
  bit HP[3]  = '{1'b0, 1'b0, 1'b1};
  bit VP[3]  = '{1'b0, 1'b0, 1'b1};

  int m_p[3]  = '{-1, -1, -1};
  int m_fc[3] = '{0, 0, 0};

  always #5 pck = ~pck;

  hvgen_param u_dut_d (
    .pck(pck), .rst(rst), .ce(ce), .resync(resync),
    .vga_hs(hs_d), .vga_vs(vs_d), .de(de_d), .hcnt(hcnt_d), .vcnt(vcnt_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef HVGEN_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  hvgen_param #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(3),
    .VACTIVE(6), .VFP(1), .VSYNC(2), .VBP(1), .CW(4)
  ) u_dut_s (
    .pck(pck), .rst(rst), .ce(ce), .resync(resync),
    .vga_hs(hs_s), .vga_vs(vs_s), .de(de_s), .hcnt(hcnt_s), .vcnt(vcnt_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef HVGEN_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  hvgen_param #(
    .HACTIVE(800), .HFP(40), .HSYNC(128), .HBP(88),
    .VACTIVE(600), .VFP(1), .VSYNC(4), .VBP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_dut_w (
    .pck(pck), .rst(rst), .ce(ce), .resync(resync),
    .vga_hs(hs_w), .vga_vs(vs_w), .de(de_w), .hcnt(hcnt_w), .vcnt(vcnt_w),
    .line_start(ls_w), .frame_start(fs_w)
`ifdef HVGEN_FRAME_CNT_EN
    , .frame_cnt(fc_w)
`endif
  );

`ifndef HVGEN_FRAME_CNT_EN
  assign fc_d = 16'd0;
  assign fc_s = 16'd0;
  assign fc_w = 16'd0;
`endif

  function automatic int htot(input int i);
    return HA[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction

  function automatic int ntot(input int i);
    return htot(i) * (VA[i] + VFP[i] + VSW[i] + VBP[i]);
  endfunction

  // Expected {h, v, hs, vs, de, ls, fs, frame_cnt} for pixel index p (p < 0: reset state).
  function automatic logic [42:0] exp_vec(input int i, input int p, input int fc);
    int h, v;
    logic hs, vs, de, ls, fs;
    logic [15:0] f;
`ifdef HVGEN_FRAME_CNT_EN
    f = 16'(fc);
`else
    f = 16'd0;
`endif
    if (p < 0) return {11'd0, 11'd0, ~HP[i], ~VP[i], 3'b000, f};
    h  = p % htot(i);
    v  = p / htot(i);
    hs = (h >= HA[i] + HFP[i] && h < HA[i] + HFP[i] + HSW[i]) ? HP[i] : ~HP[i];
    vs = (v >= VA[i] + VFP[i] && v < VA[i] + VFP[i] + VSW[i]) ? VP[i] : ~VP[i];
    de = (h < HA[i]) && (v < VA[i]);
    ls = (h == 0);
    fs = (p == 0);
    return {11'(h), 11'(v), hs, vs, de, ls, fs, f};
  endfunction

  // Model: pixel index advances on ce, resync restarts, reset parks before pixel 0.
  always @(posedge pck or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_p[i]  <= -1;
        m_fc[i] <= 0;
      end else if (ce) begin
        if (resync) begin
          m_p[i]  <= 0;
          m_fc[i] <= 0;
        end else begin
          if (m_p[i] == ntot(i) - 1) m_fc[i] <= (m_fc[i] + 1) % 65536;
          m_p[i] <= (m_p[i] + 1) % ntot(i);
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge pck) begin
    logic [42:0] act_v [3];
    logic [42:0] e;
    if (chk_en) begin
      act_v[0] = {11'(hcnt_d), 11'(vcnt_d), hs_d, vs_d, de_d, ls_d, fs_d, fc_d};
      act_v[1] = {11'(hcnt_s), 11'(vcnt_s), hs_s, vs_s, de_s, ls_s, fs_s, fc_s};
      act_v[2] = {11'(hcnt_w), 11'(vcnt_w), hs_w, vs_w, de_w, ls_w, fs_w, fc_w};
      for (int i = 0; i < 3; i++) begin
        e = exp_vec(i, m_p[i], m_fc[i]);
        n_cmp++;
        if (act_v[i] !== e) begin
          n_bad++;
          $display("FAIL model_cmp inst%0d t=%0t got %h expected %h", i, $time, act_v[i], e);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, a, e);
    end
  endtask

  // Drive inputs just after a falling edge, let one rising edge use them, return after the next fall.
  task automatic step(input bit c, input bit r);
    ce     = c;
    resync = r;
    @(negedge pck);
    #1;
  endtask

  task automatic measure(input bit tog, input int ncyc, output int per, output int vsl, output int deh);
    int first, rises;
    bit prev;
    per = -1; vsl = 0; deh = 0; first = -1; rises = 0; prev = fs_s;
    for (int c = 0; c < ncyc; c++) begin
      step(tog ? (c % 2 == 0) : 1'b1, 1'b0);
      if (fs_s && !prev) begin
        rises++;
        if (rises == 1) first = c;
        else if (rises == 2) per = c - first;
      end
      if (rises == 1) begin
        if (!vs_s) vsl++;
        if (de_s) deh++;
      end
      prev = fs_s;
    end
  endtask

  initial begin
    logic [42:0] e;
    int hs_low, de_hi, per, vsl, deh, hsh;
    bit found;
    rst = 1'b1; ce = 1'b0; resync = 1'b0;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge pck); #1;

    // Hand-computed pins on the model itself.
    e = exp_vec(0, 490 * 800, 0);       chk("model_vs_line490", e[19], 0);
    e = exp_vec(0, 492 * 800, 0);       chk("model_vs_line492", e[19], 1);
    e = exp_vec(0, 479 * 800 + 639, 0); chk("model_de_last", e[18], 1);
    e = exp_vec(0, 480 * 800, 0);       chk("model_de_line480", e[18], 0);
    e = exp_vec(2, 840, 0);             chk("model_hs840_w", e[20], 1);

    chk("rst_hcnt_d", hcnt_d, 0);
    chk("rst_hs_d", hs_d, 1);
    chk("rst_hs_w", hs_w, 0);
    chk("rst_vs_w", vs_w, 0);
    chk("rst_de_d", de_d, 0);
    chk("rst_fs_d", fs_d, 0);
    chk("rst_ls_s", ls_s, 0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    chk("rel_ce0_fs_d", fs_d, 0);

    hs_low = 0; de_hi = 0;
    for (int k = 1; k <= 800; k++) begin
      step(1'b1, 1'b0);
      if (!hs_d) hs_low++;
      if (de_d) de_hi++;
      if (k == 1) begin
        chk("first_fs_d", fs_d, 1);
        chk("first_ls_d", ls_d, 1);
        chk("first_de_d", de_d, 1);
        chk("first_hcnt_d", hcnt_d, 0);
      end
      if (k == 656) chk("hs_h655_d", hs_d, 1);
      if (k == 657) chk("hs_h656_d", hs_d, 0);
    end
    chk("line0_hcnt_d", hcnt_d, 799);
    chk("line0_vcnt_d", vcnt_d, 0);
    chk("hs_low_count_d", hs_low, 96);
    chk("de_count_d", de_hi, 640);
    step(1'b1, 1'b0);
    chk("wrap_hcnt_d", hcnt_d, 0);
    chk("wrap_vcnt_d", vcnt_d, 1);
    chk("wrap_ls_d", ls_d, 1);
    chk("wrap_fs_d", fs_d, 0);

    measure(1'b0, 400, per, vsl, deh);
    chk("period_ce1_s", per, 160);
    chk("vs_low_ce1_s", vsl, 32);
    chk("de_ce1_s", deh, 48);
    measure(1'b1, 800, per, vsl, deh);
    chk("period_half_s", per, 320);
    chk("vs_low_half_s", vsl, 64);
    chk("de_half_s", deh, 96);

    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step(1'b1, 1'b0);
      if (hcnt_s == 4'd3 && vcnt_s == 4'd2) found = 1'b1;
    end
    chk("wait_pos_s", found, 1);
    step(1'b0, 1'b1);
    chk("resync_ce0_hold_s", hcnt_s, 3);
    step(1'b1, 1'b0);
    chk("resync_not_latched_s", hcnt_s, 4);
    step(1'b1, 1'b1);
    chk("resync_hcnt_d", hcnt_d, 0);
    chk("resync_vcnt_d", vcnt_d, 0);
    chk("resync_fs_d", fs_d, 1);
    chk("resync_de_d", de_d, 1);
    chk("resync_fs_s", fs_s, 1);
    chk("resync_hcnt_w", hcnt_w, 0);
    chk("resync_fs_w", fs_w, 1);

    for (int c = 0; c < 480; c++) step(1'b1, 1'b0);
    chk("three_frames_hcnt_s", hcnt_s, 0);
    chk("three_frames_vcnt_s", vcnt_s, 0);
`ifdef HVGEN_FRAME_CNT_EN
    chk("frame_cnt3_s", fc_s, 3);
    chk("frame_cnt0_d", fc_d, 0);
`endif

    hsh = 0;
    for (int c = 0; c < 575; c++) begin
      step(1'b1, 1'b0);
      if (hs_w) hsh++;
      if (hcnt_w == 11'd839) chk("hs_h839_w", hs_w, 0);
      if (hcnt_w == 11'd840) chk("hs_h840_w", hs_w, 1);
    end
    chk("line_end_hcnt_w", hcnt_w, 1055);
    chk("hs_high_count_w", hsh, 128);
    step(1'b1, 1'b0);
    chk("wrap_hcnt_w", hcnt_w, 0);
    chk("wrap_vcnt_w", vcnt_w, 1);

    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      step(1'b1, 1'b0);
      if (hcnt_d == 10'd500) found = 1'b1;
    end
    chk("wait_h500_d", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_hcnt_d", hcnt_d, 0);
    chk("midrst_vcnt_d", vcnt_d, 0);
    chk("midrst_de_d", de_d, 0);
    chk("midrst_hs_d", hs_d, 1);
    chk("midrst_hs_w", hs_w, 0);
`ifdef HVGEN_FRAME_CNT_EN
    chk("midrst_frame_cnt_s", fc_s, 0);
`endif
    @(negedge pck); #1;
    rst = 1'b1;
    step(1'b1, 1'b0);
    chk("rerel_fs_d", fs_d, 1);
    chk("rerel_hcnt_d", hcnt_d, 0);
    for (int c = 0; c < 50; c++) step(1'b1, 1'b0);
    chk("rerel_hcnt50_d", hcnt_d, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hvgen_param.md
Name: hvgen_param

Overview:
- Parametrised video timing generator; successor to the fixed 640x480 H/V sync generator.
- Generates hcnt/vcnt, hsync/vsync with programmable polarity, display-enable, line/frame strobes and a pixel clock-enable gate.
- Drives the VGA pins and the frame-buffer read side directly.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYNC, 96, hsync pulse width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VACTIVE, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, counter width; must satisfy 2^CW >= max(HTOTAL, VTOTAL)

Ports:
- pck  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ce  in  1  pixel enable; state advances only when ce=1
- resync  in  1  restart frame at (0,0) on next ce
- vga_hs  out  1  horizontal sync, polarity per HS_POL
- vga_vs  out  1  vertical sync, polarity per VS_POL
- de  out  1  display enable (active region)
- hcnt  out  CW  horizontal position 0..HTOTAL-1
- vcnt  out  CW  vertical position 0..VTOTAL-1
- line_start  out  1  one-ce pulse at hcnt==0
- frame_start  out  1  one-ce pulse at hcnt==0 && vcnt==0

Behaviour:
- HTOTAL = HACTIVE+HFP+HSYNC+HBP (800 default); VTOTAL = VACTIVE+VFP+VSYNC+VBP (525 default).
- Reset (rst=0, async): hcnt=0, vcnt=0, vga_hs=!HS_POL, vga_vs=!VS_POL, de=0, line_start=0, frame_start=0. The first ce after reset release presents (0,0).
- All outputs are registered. vga_hs, vga_vs, de and the strobes describe the same pixel as the hcnt/vcnt values present in the same cycle, so decode uses the next-state counter values. There is no skew between position and sync.
- ce=0: every output holds its value, including the strobes. Strobes are qualified by ce downstream.
- hcnt: increments on ce; wraps HTOTAL-1 -> 0.
- vcnt: increments on the ce where hcnt wraps; wraps VTOTAL-1 -> 0 on the same edge.
- de = (hcnt < HACTIVE) && (vcnt < VACTIVE).
- hsync active for HACTIVE+HFP <= hcnt < HACTIVE+HFP+HSYNC (656..751 default).
- vsync active for VACTIVE+VFP <= vcnt < VACTIVE+VFP+VSYNC (490..491 default). Vsync edges align to hcnt==0, i.e. whole lines.
- line_start = (hcnt==0); frame_start = (hcnt==0 && vcnt==0).
- resync=1 with ce=1: next state is (0,0) with all decodes for (0,0), overriding normal increment and wrap. resync with ce=0 is ignored; it is not latched.
- Mid-operation reset: asynchronous return to reset values, no partial line emitted.
- Counter arithmetic is CW bits unsigned; no overflow is possible given the CW constraint.

Optional Feature:
- Macro HVGEN_FRAME_CNT_EN.
- Defined: extra output frame_cnt [15:0], reset 0, increments on each ce edge whose next state is (0,0) via natural wrap. It wraps 0xFFFF -> 0. resync clears it to 0.
- Undefined: no port, no logic.

Decomposition:
- Shared package vga_timing_pkg holds the default timing constants (640x480@60, 800x600@60 sets) and the HTOTAL/VTOTAL computation functions.
- One sub-module, hvgen_axis_cnt: a generic wrapping counter with enable, sync-clear, terminal-count and range-decode outputs. It is instantiated twice (horizontal and vertical).

Test Plan:
- Defaults, ce=1 constant, release reset -> frame_start at cycle 0; hcnt 799 -> 0 wrap; frame_start period exactly 420000 cycles.
- Defaults -> vga_hs low exactly when hcnt in 656..751 (96 cycles per line); vga_vs low for vcnt 490..491 (1600 cycles); de high 640 cycles on lines 0..479, never on 480..524.
- ce toggled 1/0 alternate -> same sequence as ce=1 but at half rate; outputs stable across ce=0 cycles; frame_start period 840000 cycles.
- resync pulsed at hcnt=300, vcnt=200 with ce=1 -> next cycle hcnt=0, vcnt=0, frame_start=1, de=1; resync with ce=0 -> no effect.
- HS_POL=1, VS_POL=1, HACTIVE=800, HFP=40, HSYNC=128, HBP=88, VACTIVE=600, VFP=1, VSYNC=4, VBP=23, CW=11 -> HTOTAL 1056, VTOTAL 628; hs high for hcnt 840..967.
- rst asserted mid-line (hcnt=500) -> outputs at reset values immediately, without waiting for pck. With HVGEN_FRAME_CNT_EN, frame_cnt reads 3 after 3 full frames and 0 after reset.
